dct8_stream_engine: RTL and testbench
=====================================

// Module: dct8_stream_engine
// PURPOSE
//  Parametrised 8-point 1-D DCT/IDCT engine with valid/ready handshakes on the input and output blocks.
//  Accepts one 8-sample block and computes all 8 outputs with 8 parallel MACs over 8 cycles.
//  Applies a rounded shift and saturates each output. Holds the result until the output handshake completes.
//  Drop-in successor to the fixed combinational 8-point DCT; feeds the 2-D transpose stage.
// PARAMETERS
//  IN_W       15  signed input sample width
//  OUT_W      32  signed output width (saturating)
//  OUT_SHIFT  6   right shift applied to accumulator, round-half-up; 0 = no shift/no rounding
// PORTS
//  clk        in   1         clock, all state on rising edge
//  rst_n      in   1         asynchronous active-low reset
//  in_valid   in   1         input block valid
//  in_ready   out  1         engine can accept a block this cycle
//  in_mode    in   1         0 = forward DCT, 1 = inverse (transposed matrix); sampled on accept
//  x_in       in   8*IN_W    samples, lane n at bits [n*IN_W +: IN_W], signed
//  out_valid  out  1         output block valid
//  out_ready  in   1         downstream accepts output block
//  z_out      out  8*OUT_W   results, lane k at bits [k*OUT_W +: OUT_W], signed
//  out_sat    out  1         1 if any lane of the current output block saturated
// BEHAVIOUR
//  Coefficient ROM: C[k][n] = round(64*cos((2n+1)*k*pi/16)), 8-bit signed; row k=0 is all 64.
//   cos magnitudes x64: 64,63,59,53,45,36,24,12 (angle index 0..7).
//  DCT:  acc_k = sum_n C[k][n]*x_n.   IDCT: acc_n = sum_k C[k][n]*x_k (transpose).
//  Accumulator width ACC_W = IN_W+11; no internal overflow is possible.
//  Output: (acc + (OUT_SHIFT? 2^(OUT_SHIFT-1) : 0)) >>> OUT_SHIFT, then clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//  FSM states IDLE, ACC, OUT; reset -> IDLE.
//   IDLE: in_ready=1. On in_valid -> latch x_in and in_mode, clear accumulators, idx=0, -> ACC.
//   ACC: one MAC term per lane per cycle, idx 0..7. On the edge where idx=7 -> OUT with z_out/out_sat registered.
//   OUT: out_valid=1, z_out/out_sat stable while out_ready=0.
//    On out_ready=1: transfer completes. If in_valid=1 on the same edge -> accept new block, -> ACC; else -> IDLE.
//  in_ready = (state==IDLE) | (state==OUT & out_ready). It is never asserted in ACC.
//  Latency: accept at edge E0, out_valid high after E8. Minimum block interval: 9 cycles.
//  in_valid while in_ready=0 is ignored. The source must hold its data; the engine does not buffer it.
//  Reset (any state, including mid-ACC): state=IDLE, out_valid=0, z_out=0, out_sat=0, accumulators=0.
//   The partial block is discarded. in_ready=1 the first cycle after rst_n deasserts.
//  out_sat is cleared at each new accept.
// TESTING
//  DC: DCT, all x=100, OUT_SHIFT=6 -> z0=800, z1..z7=0, out_sat=0, out_valid 8 clks after accept.
//  Impulse: DCT, x0=64, others 0 -> z = 64,63,59,53,45,36,24,12.
//  IDCT: mode=1, x0=64, others 0 -> all eight z = 64. Same data with mode=0 on the next block -> impulse result.
//  Backpressure: hold out_ready=0 for 5 clks -> z_out stable, in_ready=0.
//   Then out_ready=1 with in_valid=1 -> back-to-back accept, next out_valid 8 clks later.
//  Saturation: OUT_W=12, all x=16383 -> z0=2047, out_sat=1. Next block all x=0 -> out_sat=0.
//  Reset at ACC idx=4 -> out_valid stays 0. in_ready=1 after release. A fresh DC block yields z0=800.

Source files
------------

// File: rtl/dct8_stream_engine.sv
// 8-point 1-D DCT/IDCT engine with valid/ready block handshakes.
// One block is accepted, eight parallel MAC lanes accumulate one term each
// per cycle for eight cycles, then the rounded, shifted and saturated results
// are held until the downstream side takes them.
module dct8_stream_engine #(
  parameter int IN_W      = 15,
  parameter int OUT_W     = 32,
  parameter int OUT_SHIFT = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic [8*IN_W-1:0]    x_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*OUT_W-1:0]   z_out,
  output logic                 out_sat
);

  localparam int ACC_W  = IN_W + 11;
  localparam int PROD_W = IN_W + 8;
  localparam int WIDE_W = (ACC_W + 1 > OUT_W + 1) ? ACC_W + 1 : OUT_W + 1;

  localparam logic signed [ACC_W:0] RND =
    (OUT_SHIFT > 0) ? ((ACC_W + 1)'(1) << ((OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0)) : '0;
  localparam logic signed [WIDE_W-1:0] Z_MAX =
    {{(WIDE_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [WIDE_W-1:0] Z_MIN =
    {{(WIDE_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t                    state_q, state_d;
  logic [2:0]                idx_q, idx_d;
  logic [8*IN_W-1:0]         x_q, x_d;
  logic                      mode_q, mode_d;
  logic signed [ACC_W-1:0]   acc_q [8];
  logic signed [ACC_W-1:0]   acc_d [8];
  logic [8*OUT_W-1:0]        z_q, z_d;
  logic                      sat_q, sat_d;

  logic                      accept;
  logic signed [IN_W-1:0]    x_sel;
  logic signed [7:0]         coef_v [8];
  logic signed [PROD_W-1:0]  prod_v [8];
  logic signed [ACC_W-1:0]   acc_sum [8];
  logic signed [ACC_W:0]     rnd_v [8];
  logic signed [WIDE_W-1:0]  shf_v [8];
  logic [8*OUT_W-1:0]        z_calc;
  logic                      sat_calc;

  // C[k][n] = round(64*cos((2n+1)*k*pi/16)); the angle is folded into the
  // first quadrant using cos symmetry, so only eight magnitudes are stored.
  function automatic logic signed [7:0] coef(input logic [2:0] k, input logic [2:0] n);
    logic [4:0] m;
    logic [4:0] r;
    logic [3:0] a;
    logic       neg;
    logic [7:0] mag;
    m   = {1'b0, n, 1'b1} * {2'b00, k};
    r   = m[4] ? (5'd0 - m) : m;
    neg = (r > 5'd8);
    a   = neg ? 4'(5'd16 - r) : r[3:0];
    case (a)
      4'd0:    mag = 8'd64;
      4'd1:    mag = 8'd63;
      4'd2:    mag = 8'd59;
      4'd3:    mag = 8'd53;
      4'd4:    mag = 8'd45;
      4'd5:    mag = 8'd36;
      4'd6:    mag = 8'd24;
      4'd7:    mag = 8'd12;
      default: mag = 8'd0;
    endcase
    coef = neg ? -$signed(mag) : $signed(mag);
  endfunction

  // MAC datapath: sample idx feeds every lane; inverse mode walks the transposed matrix.
  always_comb begin
    x_sel = '0;
    for (int i = 0; i < 8; i++) begin
      if (idx_q == 3'(i)) x_sel = x_q[i*IN_W +: IN_W];
    end
    for (int j = 0; j < 8; j++) begin
      coef_v[j]  = mode_q ? coef(idx_q, 3'(j)) : coef(3'(j), idx_q);
      prod_v[j]  = coef_v[j] * x_sel;
      acc_sum[j] = acc_q[j] + ACC_W'(prod_v[j]);
    end
  end

  // Round half-up, arithmetic shift and clamp of the final accumulator values.
  always_comb begin
    z_calc   = '0;
    sat_calc = 1'b0;
    for (int j = 0; j < 8; j++) begin
      rnd_v[j] = {acc_sum[j][ACC_W-1], acc_sum[j]} + RND;
      shf_v[j] = WIDE_W'(rnd_v[j] >>> OUT_SHIFT);
      if (shf_v[j] > Z_MAX) begin
        z_calc[j*OUT_W +: OUT_W] = Z_MAX[OUT_W-1:0];
        sat_calc = 1'b1;
      end else if (shf_v[j] < Z_MIN) begin
        z_calc[j*OUT_W +: OUT_W] = Z_MIN[OUT_W-1:0];
        sat_calc = 1'b1;
      end else begin
        z_calc[j*OUT_W +: OUT_W] = shf_v[j][OUT_W-1:0];
      end
    end
  end

  // Control: accept in IDLE or on the cycle the held result is taken.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    z_d     = z_q;
    sat_d   = sat_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: accept = in_valid;
      ACC: begin
        acc_d = acc_sum;
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) begin
          state_d = OUT;
          z_d     = z_calc;
          sat_d   = sat_calc;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
          accept  = in_valid;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d = ACC;
      x_d     = x_in;
      mode_d  = in_mode;
      idx_d   = '0;
      sat_d   = 1'b0;
      for (int j = 0; j < 8; j++) acc_d[j] = '0;
    end
  end

  // State and datapath registers; reset discards any partial block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      x_q     <= '0;
      mode_q  <= 1'b0;
      z_q     <= '0;
      sat_q   <= 1'b0;
      for (int j = 0; j < 8; j++) acc_q[j] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      mode_q  <= mode_d;
      z_q     <= z_d;
      sat_q   <= sat_d;
      for (int j = 0; j < 8; j++) acc_q[j] <= acc_d[j];
    end
  end

  assign in_ready  = (state_q == IDLE) | ((state_q == OUT) & out_ready);
  assign out_valid = (state_q == OUT);
  assign z_out     = z_q;
  assign out_sat   = sat_q;

endmodule

// File: tb/tb_dct8_stream_engine.sv
// Scoreboard bench for dct8_stream_engine: a wide (OUT_W=32) and a narrow
// (OUT_W=12) engine run in lockstep on the same stimulus, each with its own
// queue of hand-computed expected blocks.
module tb_dct8_stream_engine;

  localparam int IN_W = 15;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_mode = 1'b0;
  logic                 out_ready = 1'b1;
  logic [8*IN_W-1:0]    x_in = '0;

  logic                 in_ready_w, out_valid_w, out_sat_w;
  logic [8*32-1:0]      z_w;
  logic                 in_ready_n, out_valid_n, out_sat_n;
  logic [8*12-1:0]      z_n;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    int z[8];
    bit sat;
  } exp_t;

  exp_t q_w[$];
  exp_t q_n[$];
  int   acc_cyc_q[$];
  logic prev_valid_w = 1'b0;

  dct8_stream_engine #(.IN_W(IN_W), .OUT_W(32), .OUT_SHIFT(6)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_mode(in_mode), .x_in(x_in), .out_valid(out_valid_w), .out_ready(out_ready),
    .z_out(z_w), .out_sat(out_sat_w)
  );

  dct8_stream_engine #(.IN_W(IN_W), .OUT_W(12), .OUT_SHIFT(6)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_n),
    .in_mode(in_mode), .x_in(x_in), .out_valid(out_valid_n), .out_ready(out_ready),
    .z_out(z_n), .out_sat(out_sat_n)
  );

  // Free-running clock and cycle counter used for latency measurement.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input int a0, input int a1, input int a2, input int a3,
                              input int a4, input int a5, input int a6, input int a7,
                              input bit s);
    exp_t e;
    e.z[0] = a0; e.z[1] = a1; e.z[2] = a2; e.z[3] = a3;
    e.z[4] = a4; e.z[5] = a5; e.z[6] = a6; e.z[7] = a7;
    e.sat = s;
    return e;
  endfunction

  function automatic logic [8*IN_W-1:0] packAll(input int v);
    logic [8*IN_W-1:0] r;
    for (int k = 0; k < 8; k++) r[k*IN_W +: IN_W] = IN_W'(v);
    return r;
  endfunction

  function automatic logic [8*IN_W-1:0] packOne(input int lane, input int v);
    logic [8*IN_W-1:0] r;
    r = '0;
    r[lane*IN_W +: IN_W] = IN_W'(v);
    return r;
  endfunction

  task automatic checkOutput(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic failNow(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s got=no-event want=event", name);
  endtask

  task automatic checkBlock(input string name, input int got[8], input logic got_sat,
                            input exp_t e);
    int lane;
    lane = -1;
    for (int k = 0; k < 8; k++) begin
      if (got[k] != e.z[k] && lane < 0) lane = k;
    end
    total++;
    if (lane >= 0) begin
      bad++;
      $display("[TB] FAIL %s lane=%0d got=%0d want=%0d", name, lane, got[lane], e.z[lane]);
    end
    checkOutput({name, "_sat"}, int'(got_sat), int'(e.sat));
  endtask

  // Drive one block (called just after a rising edge) and hold it until accepted.
  task automatic applyStimulus(input bit mode, input logic [8*IN_W-1:0] x,
                               input exp_t ew, input exp_t en, input bit track);
    bit ok;
    if (track) begin
      q_w.push_back(ew);
      q_n.push_back(en);
    end
    in_valid = 1'b1;
    in_mode  = mode;
    x_in     = x;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready_w) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      failNow("accept_timeout");
    end else begin
      @(posedge clk);
      #1;
      if (track) acc_cyc_q.push_back(cyc);
    end
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q_w.size() == 0 && q_n.size() == 0) break;
    end
    checkOutput("drain_w", q_w.size(), 0);
    checkOutput("drain_n", q_n.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: latency on each new result, scoreboard compare on each handshake.
  always @(negedge clk) begin
    int got_w[8];
    int got_n[8];
    exp_t e;
    int a;
    if (rst_n) begin
      if (out_valid_w && !prev_valid_w) begin
        if (acc_cyc_q.size() == 0) begin
          failNow("latency_unexpected_valid");
        end else begin
          a = acc_cyc_q.pop_front();
          checkOutput("latency", cyc - a, 8);
        end
      end
      if (out_valid_w && out_ready) begin
        for (int k = 0; k < 8; k++) got_w[k] = $signed(z_w[k*32 +: 32]);
        if (q_w.size() == 0) begin
          failNow("unexpected_block_w");
        end else begin
          e = q_w.pop_front();
          checkBlock("block_w", got_w, out_sat_w, e);
        end
      end
      if (out_valid_n && out_ready) begin
        for (int k = 0; k < 8; k++) got_n[k] = int'($signed(z_n[k*12 +: 12]));
        if (q_n.size() == 0) begin
          failNow("unexpected_block_n");
        end else begin
          e = q_n.pop_front();
          checkBlock("block_n", got_n, out_sat_n, e);
        end
      end
    end
    prev_valid_w <= out_valid_w;
  end

  // Directed sequence of blocks with hand-computed results.
  initial begin
    exp_t dc, imp, allc, neg_imp;
    bit   seen;
    bit   ok;
    dc      = mk(800, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    imp     = mk(64, 63, 59, 53, 45, 36, 24, 12, 1'b0);
    allc    = mk(64, 64, 64, 64, 64, 64, 64, 64, 1'b0);
    neg_imp = mk(-64, -63, -59, -53, -45, -36, -24, -12, 1'b0);

    @(negedge clk);
    checkOutput("reset_out_valid", int'(out_valid_w), 0);
    checkOutput("reset_out_sat", int'(out_sat_w), 0);
    checkOutput("reset_z_nonzero", (z_w == '0) ? 0 : 1, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("in_ready_after_reset", int'(in_ready_w), 1);
    @(posedge clk);
    #1;

    applyStimulus(1'b0, packAll(100), dc, dc, 1'b1);
    applyStimulus(1'b0, packOne(0, 64), imp, imp, 1'b1);
    applyStimulus(1'b1, packOne(0, 64), allc, allc, 1'b1);
    applyStimulus(1'b0, packOne(0, 64), imp, imp, 1'b1);
    applyStimulus(1'b0, packOne(1, 1), mk(1, 1, 0, 0, -1, -1, -1, -1, 1'b0),
                  mk(1, 1, 0, 0, -1, -1, -1, -1, 1'b0), 1'b1);
    applyStimulus(1'b1, packOne(1, 1), mk(1, 1, 1, 0, 0, -1, -1, -1, 1'b0),
                  mk(1, 1, 1, 0, 0, -1, -1, -1, 1'b0), 1'b1);
    applyStimulus(1'b0, packAll(16383), mk(131064, 0, 0, 0, 0, 0, 0, 0, 1'b0),
                  mk(2047, 0, 0, 0, 0, 0, 0, 0, 1'b1), 1'b1);
    applyStimulus(1'b0, packAll(0), mk(0, 0, 0, 0, 0, 0, 0, 0, 1'b0),
                  mk(0, 0, 0, 0, 0, 0, 0, 0, 1'b0), 1'b1);
    applyStimulus(1'b0, packAll(-16384), mk(-131072, 0, 0, 0, 0, 0, 0, 0, 1'b0),
                  mk(-2048, 0, 0, 0, 0, 0, 0, 0, 1'b1), 1'b1);
    waitDrain();

    // Backpressure: result must sit still and input must stay blocked.
    out_ready = 1'b0;
    applyStimulus(1'b0, packAll(-50), mk(-400, 0, 0, 0, 0, 0, 0, 0, 1'b0),
                  mk(-400, 0, 0, 0, 0, 0, 0, 0, 1'b0), 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid_w) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) failNow("bp_out_valid_timeout");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("bp_out_valid", int'(out_valid_w), 1);
      checkOutput("bp_in_ready", int'(in_ready_w), 0);
      checkOutput("bp_z0", $signed(z_w[31:0]), -400);
      checkOutput("bp_z1", $signed(z_w[63:32]), 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    applyStimulus(1'b0, packOne(0, -64), neg_imp, neg_imp, 1'b1);
    waitDrain();

    // Reset in the middle of accumulation (idx=4) discards the block.
    applyStimulus(1'b0, packAll(100), dc, dc, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_out_valid", int'(out_valid_w), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_in_ready", int'(in_ready_w), 1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid_w) seen = 1'b1;
    end
    checkOutput("midrst_no_output", int'(seen), 0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, packAll(100), dc, dc, 1'b1);
    waitDrain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
